sbox_table_loader: RTL and testbench
====================================

// Module: sbox_table_loader
// PURPOSE
//  Controller that fills the eight LookupTable units of the SBox datapath through its shared
//  memory-mapped write port, then lets software fire the datapath with a one-cycle run pulse.
//  Takes a stream of table words on a valid/ready source port.
//  Broadcasts each word, entry by entry, to every unit selected by a mask.
//  Sits between a DMA/AXI word stream and the SBox valid/addr/wstrb/wdata/ready port.
// PARAMETERS
//  DATA_W      32    table word width; sb_wstrb is DATA_W/8 bits
//  TABLE_DEPTH 256   entries per unit; entry index drives sb_addr[7:0]; must be <= 256
//  TIMEOUT     1024  max cycles a write waits for sb_ready before abort; 0 = never abort
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous, active-low reset
//  start      in   1            load request pulse, sampled in IDLE only
//  unit_mask  in   8            units to load, latched on accepted start; bit i = unit i
//  run_req    in   1            request one run pulse, sampled in IDLE only
//  src_valid  in   1            source word valid
//  src_data   in   DATA_W       source table word, entry order 0..TABLE_DEPTH-1
//  src_ready  out  1            loader accepts word this cycle
//  sb_valid   out  1            SBox access valid
//  sb_addr    out  11           {unit code[2:0], entry[7:0]}
//  sb_wstrb   out  DATA_W/8     all ones while sb_valid, else 0
//  sb_wdata   out  DATA_W       captured source word
//  sb_ready   in   1            SBox access ready (OR of unit readies)
//  run        out  1            one-cycle run pulse to SBox
//  busy       out  1            high in FETCH/WRITE
//  done       out  1            one-cycle pulse at end of load (normal or abort)
//  err        out  1            timeout abort flag; held until next accepted start
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE; all outputs 0; entry, unit pointer, timer, mask, err cleared.
//  Reset mid-load abandons the load with no done pulse; units keep partially written contents.
//  Unit code for sb_addr[10:8], fixed:
//    u0=111  u1=100  u2=110  u3=000  u4=001  u5=010  u6=011  u7=101
//  FSM states: IDLE, FETCH, WRITE, DONE.
//  IDLE:
//    start=1: latch mask, clear err, entry=0.
//      Mask nonzero: go to FETCH. Mask zero: go to DONE.
//    start=0 and run_req=1: run=1 next cycle, exactly one cycle.
//    start and run_req together: start wins, run_req dropped.
//    start/run_req outside IDLE are ignored, not queued.
//  FETCH:
//    src_ready=1 combinationally.
//    On src_valid: capture src_data into sb_wdata, set unit pointer = lowest set mask bit, go to WRITE.
//  WRITE:
//    sb_valid=1; sb_addr/sb_wdata stable until the beat completes (sb_valid&sb_ready at edge).
//    On completion, pointer moves to next set mask bit above it, ascending, and state stays WRITE.
//    If no set bit remains:
//      entry==TABLE_DEPTH-1: go to DONE.
//      Otherwise: entry++, go to FETCH.
//  Timer:
//    Cleared at start of each beat.
//    TIMEOUT!=0 and TIMEOUT cycles elapse with sb_ready=0: drop sb_valid, set err, go to DONE.
//  DONE: done=1 for one cycle, go to IDLE; sb_valid=0, src_ready=0.
//  busy = (state==FETCH||state==WRITE).
//  Latency, sb_ready and src_valid held 1, k units masked:
//    start -> done = 1 + TABLE_DEPTH*(1+k) + 1 cycles.
//  Exactly TABLE_DEPTH source words consumed per load; extra words are left on the source.
// TESTING
//  mask=8'hFF, ready/valid stuck 1, data=entry index
//    -> 2048 writes, unit order u0..u7 per entry
//    -> first sb_addr 11'h700, last 11'h5FF; done at cycle 2306 after start
//  mask=8'h05, src_valid toggling every other cycle, sb_ready random 50%
//    -> only codes 111 and 110 seen; wdata matches stream; no beat lost or repeated
//  mask=8'h00 -> done pulse 2 cycles after start; no sb_valid, no src_ready, err=0
//  TIMEOUT=16, sb_ready stuck 0 at entry 3 unit 2
//    -> sb_valid drops after 16 cycles; err=1 and done pulse; err cleared by next start
//  run_req in IDLE -> run high exactly 1 cycle
//    run_req with start, or while busy -> no run pulse
//  rst=0 for 1 cycle during entry 100 -> all outputs 0 next cycle, no done; fresh start reloads entry 0

Source files
------------

// File: rtl/sbox_table_loader.sv
// sbox_table_loader: streams table words into the masked SBox LookupTable units,
// one broadcast beat per selected unit per entry, and issues single-cycle run pulses.
module sbox_table_loader #(
  parameter int DATA_W      = 32,
  parameter int TABLE_DEPTH = 256,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            unit_mask,
  input  logic                  run_req,
  input  logic                  src_valid,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  src_ready,
  output logic                  sb_valid,
  output logic [10:0]           sb_addr,
  output logic [DATA_W/8-1:0]   sb_wstrb,
  output logic [DATA_W-1:0]     sb_wdata,
  input  logic                  sb_ready,
  output logic                  run,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  // SBox address decode of units 7..0, packed high to low
  localparam logic [23:0] CODES = {3'b101, 3'b011, 3'b010, 3'b001,
                                   3'b000, 3'b110, 3'b100, 3'b111};
  state_t      state;
  logic [7:0]  mask;
  logic [7:0]  entry;
  logic [2:0]  ptr;
  logic [31:0] tmr;
  logic [3:0]  nxt;
  logic [2:0]  low;
  logic        tmo;
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] p);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) r = (m[i] && 4'(i) > {1'b0, p}) ? {1'b1, 3'(i)} : r;
    return r;
  endfunction
  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) r = m[i] ? 3'(i) : r;
    return r;
  endfunction
  assign nxt       = next_above(mask, ptr);
  assign low       = lowest(mask);
  assign tmo       = (TIMEOUT != 0) && !sb_ready && (tmr == 32'(TIMEOUT - 1));
  assign src_ready = state == FETCH;
  assign sb_valid  = state == WRITE;
  assign busy      = src_ready || sb_valid;
  assign sb_addr   = sb_valid ? {CODES[3*ptr +: 3], entry} : 11'd0;
  assign sb_wstrb  = sb_valid ? '1 : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      mask     <= '0;
      entry    <= '0;
      ptr      <= '0;
      tmr      <= '0;
      sb_wdata <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      run  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask  <= unit_mask;
            err   <= 1'b0;
            entry <= '0;
            state <= |unit_mask ? FETCH : DONE;
          end else if (run_req) begin
            run <= 1'b1;
          end
        end
        FETCH: begin
          if (src_valid) begin
            sb_wdata <= src_data;
            ptr      <= low;
            tmr      <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (sb_ready) begin
            tmr <= '0;
            if (nxt[3]) begin
              ptr <= nxt[2:0];
            end else if (entry == 8'(TABLE_DEPTH - 1)) begin
              state <= DONE;
            end else begin
              entry <= entry + 8'd1;
              state <= FETCH;
            end
          end else if (tmo) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_table_loader.sv
// tb_sbox_table_loader: directed checks of load order, latency, timeout abort,
// run pulse gating and mid-load reset for sbox_table_loader.
module tb_sbox_table_loader;
  logic        clk = 0, rst = 0, start = 0, run_req = 0, src_valid = 0, sb_ready = 0;
  logic [7:0]  unit_mask = 0;
  logic [31:0] src_data = 0;
  logic        src_ready, sb_valid, run, busy, done, err;
  logic [10:0] sb_addr;
  logic [3:0]  sb_wstrb;
  logic [31:0] sb_wdata;

  sbox_table_loader #(.DATA_W(32), .TABLE_DEPTH(256), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .unit_mask(unit_mask), .run_req(run_req),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .sb_valid(sb_valid), .sb_addr(sb_addr), .sb_wstrb(sb_wstrb), .sb_wdata(sb_wdata),
    .sb_ready(sb_ready), .run(run), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [2:0]  code [8] = '{3'b111, 3'b100, 3'b110, 3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
  logic [10:0] qa [$];
  logic [31:0] qd [$];
  int n_chk = 0, n_fail = 0;
  int cyc, widx, n_src, n_run, run_cyc, n_done, done_cyc, n_sbv, n_srdy, stall_cnt, zrun;
  int vmode = 0, rmode = 0, bad;
  bit acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample at negedge, then drive the next cycle's inputs just after posedge
  task automatic tick();
    @(negedge clk);
    acc = src_valid && src_ready;
    if (sb_valid && sb_ready) begin
      qa.push_back(sb_addr);
      qd.push_back(sb_wdata);
    end
    if (acc) n_src++;
    if (run) begin n_run++; run_cyc = cyc; end
    if (done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
    if (sb_valid) n_sbv++;
    if (src_ready) n_srdy++;
    if (sb_valid && sb_addr == 11'h603) stall_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) widx++;
    src_data  = widx;
    src_valid = (vmode == 0) ? 1'b1 : ~src_valid;
    if (rmode == 0) sb_ready = 1'b1;
    else if (rmode == 1) begin
      sb_ready = (zrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      zrun = sb_ready ? 0 : zrun + 1;
    end else sb_ready = !(sb_valid && sb_addr == 11'h603);
  endtask

  task automatic clr();
    qa.delete();
    qd.delete();
    n_src = 0; n_run = 0; run_cyc = -1; n_done = 0; done_cyc = -1;
    n_sbv = 0; n_srdy = 0; stall_cnt = 0; zrun = 0; cyc = 0; widx = 0;
    src_data = 0;
  endtask

  task automatic go(input logic [7:0] m, input logic rq);
    clr();
    unit_mask = m;
    start = 1;
    run_req = rq;
    tick();
    start = 0;
    run_req = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    while (done_cyc < 0 && cyc < budget) tick();
    chk(tag, done_cyc >= 0, 1);
  endtask

  initial begin
    clr();
    repeat (3) tick();
    chk("reset_outputs", {src_ready, sb_valid, sb_addr, sb_wstrb, sb_wdata, run, busy, done, err}, 0);
    rst = 1;
    tick();

    // full mask, stream always valid, sbox always ready
    go(8'hFF, 0);
    wait_done("ff_done_seen", 3000);
    chk("ff_done_cycle", done_cyc, 2306);
    chk("ff_write_count", qa.size(), 2048);
    chk("ff_src_words", n_src, 256);
    bad = 0;
    foreach (qa[j]) if (qa[j] !== {code[j % 8], 8'(j / 8)} || qd[j] !== 32'(j / 8)) bad++;
    chk("ff_order", bad, 0);
    chk("ff_first_addr", qa[0], 11'h700);
    chk("ff_last_addr", qa[$], 11'h5FF);
    tick(); tick();
    chk("ff_done_width", n_done, 1);
    chk("ff_err", err, 0);
    chk("ff_idle_src_ready", src_ready, 0);

    // mask 05, toggling valid, random ready
    vmode = 1; rmode = 1;
    go(8'h05, 0);
    wait_done("m05_done_seen", 5000);
    chk("m05_write_count", qa.size(), 512);
    chk("m05_src_words", n_src, 256);
    bad = 0;
    foreach (qa[j]) if (qa[j] !== {(j % 2 == 0) ? 3'b111 : 3'b110, 8'(j / 2)} || qd[j] !== 32'(j / 2)) bad++;
    chk("m05_order", bad, 0);
    chk("m05_err", err, 0);

    // empty mask
    vmode = 0; rmode = 0;
    go(8'h00, 0);
    wait_done("m00_done_seen", 20);
    chk("m00_done_cycle", done_cyc, 2);
    chk("m00_no_sb_valid", n_sbv, 0);
    chk("m00_no_src_ready", n_srdy, 0);
    chk("m00_err", err, 0);

    // sbox stalls on entry 3, unit 2
    rmode = 2;
    go(8'h04, 0);
    wait_done("tmo_done_seen", 200);
    chk("tmo_stall_cycles", stall_cnt, 16);
    chk("tmo_err_set", err, 1);
    chk("tmo_writes", qa.size(), 3);
    chk("tmo_src_words", n_src, 4);
    rmode = 0;
    go(8'h00, 0);
    chk("tmo_err_cleared", err, 0);
    wait_done("clr_done_seen", 20);

    // run pulses
    clr();
    run_req = 1;
    tick();
    run_req = 0;
    repeat (4) tick();
    chk("run_count", n_run, 1);
    chk("run_cycle", run_cyc, 1);
    go(8'h00, 1);
    wait_done("run_start_done", 20);
    repeat (3) tick();
    chk("run_with_start", n_run, 0);
    go(8'h01, 0);
    repeat (20) tick();
    run_req = 1;
    repeat (5) tick();
    run_req = 0;
    wait_done("run_busy_done", 1000);
    repeat (3) tick();
    chk("run_while_busy", n_run, 0);

    // reset in the middle of entry 100
    go(8'hFF, 0);
    while (!(sb_valid && sb_addr[7:0] == 8'd100) && cyc < 2000) tick();
    chk("rst_reached_entry100", sb_valid && sb_addr[7:0] == 8'd100, 1);
    rst = 0;
    tick();
    rst = 1;
    chk("rst_outputs", {src_ready, sb_valid, sb_addr, sb_wstrb, sb_wdata, run, busy, done, err}, 0);
    n_done = 0;
    repeat (10) tick();
    chk("rst_no_done", n_done, 0);
    go(8'h01, 0);
    repeat (6) tick();
    chk("rst_reload_addr0", qa[0], 11'h700);
    chk("rst_reload_data0", qd[0], 0);
    chk("rst_reload_addr1", qa[1], 11'h701);
    chk("rst_reload_data1", qd[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
